// File: rtl/msd_dimm_pkg.sv
// Shared DDR5 command/request types, default timings and address decode helpers
// for the MSD memory controller.
package msd_dimm_pkg;

   typedef enum logic [2:0] {
      CMD_NOP  = 3'd0,
      CMD_ACT0 = 3'd1,
      CMD_ACT1 = 3'd2,
      CMD_RD0  = 3'd3,
      CMD_RD1  = 3'd4,
      CMD_WR0  = 3'd5,
      CMD_WR1  = 3'd6,
      CMD_PRE  = 3'd7
   } cmd_e;

   typedef enum logic [1:0] {
      OP_RD     = 2'd0,
      OP_WR     = 2'd1,
      OP_IFETCH = 2'd2,
      OP_ILL    = 2'd3
   } req_op_e;

   // Request as held in the queue: already decoded into DIMM coordinates.
   typedef struct packed {
      req_op_e     op;
      logic        chan;
      logic [2:0]  bg;
      logic [1:0]  ba;
      logic [15:0] row;
      logic [9:0]  col;
   } req_t;

   localparam int PHYS_W     = 34;
   localparam int NUM_BANKS  = 32;

   localparam int DEF_T_RCD    = 39;
   localparam int DEF_T_RP     = 39;
   localparam int DEF_T_RAS    = 76;
   localparam int DEF_T_RTP    = 18;
   localparam int DEF_T_WR_PRE = 118;
   localparam int DEF_T_CCD    = 12;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int sat_sub(input int a, input int b);
      return (a > b) ? a - b : 0;
   endfunction

   function automatic logic get_chan(input logic [PHYS_W-1:0] a);
      return a[6];
   endfunction

   function automatic logic [2:0] get_bg(input logic [PHYS_W-1:0] a);
      return a[9:7];
   endfunction

   function automatic logic [1:0] get_ba(input logic [PHYS_W-1:0] a);
      return a[11:10];
   endfunction

   function automatic logic [15:0] get_row(input logic [PHYS_W-1:0] a);
      return a[33:18];
   endfunction

   function automatic logic [9:0] get_col(input logic [PHYS_W-1:0] a);
      return {a[17:12], a[5:2]};
   endfunction

   function automatic req_t decode_req(input logic [1:0] op, input logic [PHYS_W-1:0] a);
      req_t r;
      r.op   = req_op_e'(op);
      r.chan = get_chan(a);
      r.bg   = get_bg(a);
      r.ba   = get_ba(a);
      r.row  = get_row(a);
      r.col  = get_col(a);
      return r;
   endfunction

endpackage

// File: rtl/msd_req_fifo.sv
// Show-ahead request FIFO: head entry is visible combinationally while the
// queue is non-empty; push is ignored when full, pop when empty.
module msd_req_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 34
) (
   input  logic                         clk,
   input  logic                         srst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/msd_cmd_scheduler.sv
// DDR5 command scheduler: in-order request queue, per-bank open-row table and
// timed ACT/CAS/PRE sequencing onto a registered DIMM command bus.
module msd_cmd_scheduler
   import msd_dimm_pkg::*;
#(
   parameter int QUEUE_DEPTH = 16,
   parameter int ADDR_W      = 34,
   parameter int OPEN_PAGE   = 0,
   parameter int T_RCD       = DEF_T_RCD,
   parameter int T_RP        = DEF_T_RP,
   parameter int T_RAS       = DEF_T_RAS,
   parameter int T_RTP       = DEF_T_RTP,
   parameter int T_WR_PRE    = DEF_T_WR_PRE,
   parameter int T_CCD       = DEF_T_CCD
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [1:0]                        req_op,
   input  logic [ADDR_W-1:0]                 req_addr,
   output logic                              req_err,
   output logic                              cmd_valid,
   output cmd_e                              cmd_type,
   output logic                              cmd_chan,
   output logic [2:0]                        cmd_bg,
   output logic [1:0]                        cmd_ba,
   output logic [15:0]                       cmd_row,
   output logic [9:0]                        cmd_col,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]  q_count,
   output logic                              q_full
);

   localparam int T_MAX = max_i(max_i(max_i(T_RCD, T_RP), max_i(T_RAS, T_RTP)),
                                max_i(T_WR_PRE, T_CCD));
   localparam int TW    = $clog2(T_MAX) + 1;

   // A timer loaded at the edge that drives command A reads zero in the cycle
   // where the FSM decides; B then appears 2 edges later (3 via IDLE after WAIT_RP).
   localparam logic [TW-1:0] LD_RCD = TW'(sat_sub(T_RCD, 2));
   localparam logic [TW-1:0] LD_CCD = TW'(sat_sub(T_CCD, 2));
   localparam logic [TW-1:0] LD_RAS = TW'(sat_sub(T_RAS, 2));
   localparam logic [TW-1:0] LD_RTP = TW'(sat_sub(T_RTP, 2));
   localparam logic [TW-1:0] LD_WR  = TW'(sat_sub(T_WR_PRE, 2));
   localparam logic [TW-1:0] LD_RP  = TW'(sat_sub(T_RP, 3));

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_ACT0     = 4'd1;
   localparam logic [3:0] ST_ACT1     = 4'd2;
   localparam logic [3:0] ST_WAIT_CAS = 4'd3;
   localparam logic [3:0] ST_CAS0     = 4'd4;
   localparam logic [3:0] ST_CAS1     = 4'd5;
   localparam logic [3:0] ST_WAIT_PRE = 4'd6;
   localparam logic [3:0] ST_PRE      = 4'd7;
   localparam logic [3:0] ST_WAIT_RP  = 4'd8;

   function automatic logic [TW-1:0] dec(input logic [TW-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

   function automatic logic [TW-1:0] tmax(input logic [TW-1:0] a, input logic [TW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [3:0]    state_reg, state_next;
   logic [TW-1:0] rcd_reg, ccd_reg, pre_reg, rp_reg;
   req_t          head_req, push_req, cur_req_reg;
   logic          q_empty, push, pop, cur_is_wr;
   logic [4:0]    head_bank, cur_bank;
   logic          bank_valid_reg [NUM_BANKS];
   logic [15:0]   bank_row_reg   [NUM_BANKS];
   logic          bank_hit, bank_conflict;
   cmd_e          cmd_next;

   assign req_ready = !q_full;
   assign push      = req_valid && req_ready && (req_op != 2'd3);
   assign pop       = (state_reg == ST_CAS1);
   assign push_req  = decode_req(req_op, PHYS_W'(req_addr));

   msd_req_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH ($bits(req_t))
   ) u_fifo (
      .clk       (clk),
      .srst      (rst),
      .push      (push),
      .push_data (push_req),
      .pop       (pop),
      .head      (head_req),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   assign head_bank     = {head_req.bg, head_req.ba};
   assign cur_bank      = {cur_req_reg.bg, cur_req_reg.ba};
   assign cur_is_wr     = (cur_req_reg.op == OP_WR);
   assign bank_hit      = (OPEN_PAGE != 0) && bank_valid_reg[head_bank] &&
                          (bank_row_reg[head_bank] == head_req.row);
   assign bank_conflict = (OPEN_PAGE != 0) && bank_valid_reg[head_bank] &&
                          (bank_row_reg[head_bank] != head_req.row);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (!q_empty) begin
               if (bank_hit)           state_next = ST_WAIT_CAS;
               else if (bank_conflict) state_next = ST_WAIT_PRE;
               else                    state_next = ST_ACT0;
            end
         end
         ST_ACT0:     state_next = ST_ACT1;
         ST_ACT1:     state_next = ST_WAIT_CAS;
         ST_WAIT_CAS: if (rcd_reg == '0 && ccd_reg == '0) state_next = ST_CAS0;
         ST_CAS0:     state_next = ST_CAS1;
         ST_CAS1:     state_next = (OPEN_PAGE != 0) ? ST_IDLE : ST_WAIT_PRE;
         ST_WAIT_PRE: if (pre_reg == '0) state_next = ST_PRE;
         ST_PRE:      state_next = ST_WAIT_RP;
         ST_WAIT_RP:  if (rp_reg == '0) state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_next = CMD_NOP;
      case (state_reg)
         ST_ACT0: cmd_next = CMD_ACT0;
         ST_ACT1: cmd_next = CMD_ACT1;
         ST_CAS0: cmd_next = cur_is_wr ? CMD_WR0 : CMD_RD0;
         ST_CAS1: cmd_next = cur_is_wr ? CMD_WR1 : CMD_RD1;
         ST_PRE:  cmd_next = CMD_PRE;
         default: cmd_next = CMD_NOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         rcd_reg     <= '0;
         ccd_reg     <= '0;
         pre_reg     <= '0;
         rp_reg      <= '0;
         cur_req_reg <= '0;
         req_err     <= 1'b0;
         cmd_valid   <= 1'b0;
         cmd_type    <= CMD_NOP;
         cmd_chan    <= 1'b0;
         cmd_bg      <= '0;
         cmd_ba      <= '0;
         cmd_row     <= '0;
         cmd_col     <= '0;
      end else begin
         state_reg <= state_next;
         req_err   <= req_valid && req_ready && (req_op == 2'd3);
         if (state_reg == ST_IDLE && !q_empty) cur_req_reg <= head_req;

         rcd_reg <= (state_reg == ST_ACT0) ? LD_RCD : dec(rcd_reg);
         ccd_reg <= (state_reg == ST_CAS0) ? LD_CCD : dec(ccd_reg);
         rp_reg  <= (state_reg == ST_PRE)  ? LD_RP  : dec(rp_reg);
         // A single pre-timer covers every bank, so it only ever extends.
         if (state_reg == ST_ACT0)      pre_reg <= tmax(dec(pre_reg), LD_RAS);
         else if (state_reg == ST_CAS0) pre_reg <= tmax(dec(pre_reg), cur_is_wr ? LD_WR : LD_RTP);
         else                           pre_reg <= dec(pre_reg);

         cmd_valid <= (cmd_next != CMD_NOP);
         cmd_type  <= cmd_next;
         cmd_chan  <= (cmd_next != CMD_NOP) ? cur_req_reg.chan : 1'b0;
         cmd_bg    <= (cmd_next != CMD_NOP) ? cur_req_reg.bg   : 3'd0;
         cmd_ba    <= (cmd_next != CMD_NOP) ? cur_req_reg.ba   : 2'd0;
         cmd_row   <= (cmd_next != CMD_NOP) ? cur_req_reg.row  : 16'd0;
         cmd_col   <= (cmd_next != CMD_NOP) ? cur_req_reg.col  : 10'd0;
      end
   end

   for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      always_ff @(posedge clk) begin
         if (rst) begin
            bank_valid_reg[gi] <= 1'b0;
         end else if (cur_bank == 5'(gi)) begin
            if (state_reg == ST_ACT0)     bank_valid_reg[gi] <= 1'b1;
            else if (state_reg == ST_PRE) bank_valid_reg[gi] <= 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (state_reg == ST_ACT0 && cur_bank == 5'(gi)) bank_row_reg[gi] <= cur_req_reg.row;
      end
   end

endmodule

// File: tb/tb_msd_cmd_scheduler.sv
// Directed bench for msd_cmd_scheduler: a close-page and an open-page instance,
// command timing checked against hand-computed cycle numbers.
module tb_msd_cmd_scheduler;
   import msd_dimm_pkg::*;

   localparam logic [33:0] ADDR_A = 34'h0_0004_0C80;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_op = 2'd0;
   logic [33:0] req_addr = '0;
   logic        c_req_valid = 1'b0, o_req_valid = 1'b0;

   logic        c_req_ready, c_req_err, c_cmd_valid, c_cmd_chan, c_q_full;
   cmd_e        c_cmd_type;
   logic [2:0]  c_cmd_bg;
   logic [1:0]  c_cmd_ba;
   logic [15:0] c_cmd_row;
   logic [9:0]  c_cmd_col;
   logic [4:0]  c_q_count;

   logic        o_req_ready, o_req_err, o_cmd_valid, o_cmd_chan, o_q_full;
   cmd_e        o_cmd_type;
   logic [2:0]  o_cmd_bg;
   logic [1:0]  o_cmd_ba;
   logic [15:0] o_cmd_row;
   logic [9:0]  o_cmd_col;
   logic [4:0]  o_q_count;

   int checks = 0, failures = 0, cyc = -1;
   int          stim_op[$];
   logic [33:0] stim_addr[$];
   int ev_cyc[$], ev_type[$], ev_bg[$], ev_ba[$], ev_row[$], ev_col[$];

   always #5 clk = ~clk;

   msd_cmd_scheduler #(.OPEN_PAGE(0)) u_close (
      .clk(clk), .rst(rst), .req_valid(c_req_valid), .req_ready(c_req_ready),
      .req_op(req_op), .req_addr(req_addr), .req_err(c_req_err),
      .cmd_valid(c_cmd_valid), .cmd_type(c_cmd_type), .cmd_chan(c_cmd_chan),
      .cmd_bg(c_cmd_bg), .cmd_ba(c_cmd_ba), .cmd_row(c_cmd_row), .cmd_col(c_cmd_col),
      .q_count(c_q_count), .q_full(c_q_full)
   );

   msd_cmd_scheduler #(.OPEN_PAGE(1)) u_open (
      .clk(clk), .rst(rst), .req_valid(o_req_valid), .req_ready(o_req_ready),
      .req_op(req_op), .req_addr(req_addr), .req_err(o_req_err),
      .cmd_valid(o_cmd_valid), .cmd_type(o_cmd_type), .cmd_chan(o_cmd_chan),
      .cmd_bg(o_cmd_bg), .cmd_ba(o_cmd_ba), .cmd_row(o_cmd_row), .cmd_col(o_cmd_col),
      .q_count(o_q_count), .q_full(o_q_full)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_ev(input string tag, input int idx, input cmd_e t, input int c);
      if (idx < ev_cyc.size()) begin
         check({tag, "_type"}, ev_type[idx], int'(t));
         check({tag, "_cyc"}, ev_cyc[idx], c);
      end else begin
         check({tag, "_missing"}, ev_cyc.size(), idx + 1);
      end
   endtask

   task automatic clear_log();
      ev_cyc.delete(); ev_type.delete(); ev_bg.delete();
      ev_ba.delete(); ev_row.delete(); ev_col.delete();
      cyc = -1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      c_req_valid = 1'b0;
      o_req_valid = 1'b0;
      stim_op.delete();
      stim_addr.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_log();
   endtask

   task automatic push_req(input int op, input logic [33:0] addr);
      stim_op.push_back(op);
      stim_addr.push_back(addr);
   endtask

   // Cycle n is observed #1 after edge n; the first edge of a run is edge 0.
   task automatic run(input int n, input bit sel);
      for (int i = 0; i < n; i++) begin
         bit rdy, take;
         rdy  = sel ? o_req_ready : c_req_ready;
         take = (stim_op.size() > 0);
         if (take) begin
            req_op   = 2'(stim_op[0]);
            req_addr = stim_addr[0];
         end
         c_req_valid = take && !sel;
         o_req_valid = take && sel;
         @(posedge clk);
         #1 cyc++;
         if (take && rdy) begin
            void'(stim_op.pop_front());
            void'(stim_addr.pop_front());
         end
         if (sel ? o_cmd_valid : c_cmd_valid) begin
            cmd_e t;
            t = sel ? o_cmd_type : c_cmd_type;
            ev_cyc.push_back(cyc);
            ev_type.push_back(int'(t));
            ev_bg.push_back(int'(sel ? o_cmd_bg : c_cmd_bg));
            ev_ba.push_back(int'(sel ? o_cmd_ba : c_cmd_ba));
            ev_row.push_back(int'(sel ? o_cmd_row : c_cmd_row));
            ev_col.push_back(int'(sel ? o_cmd_col : c_cmd_col));
            $display("%s cyc=%0d cmd=%s bg=%0d ba=%0d row=%0d col=%0d", sel ? "open " : "close",
                     cyc, t.name(), ev_bg[$], ev_ba[$], ev_row[$], ev_col[$]);
         end
      end
      c_req_valid = 1'b0;
      o_req_valid = 1'b0;
   endtask

   initial begin
      reset_dut();
      check("rst_cmd_valid", c_cmd_valid, 0);
      check("rst_cmd_type", int'(c_cmd_type), int'(CMD_NOP));
      check("rst_fields", {c_cmd_chan, c_cmd_bg, c_cmd_ba, c_cmd_row, c_cmd_col}, 0);
      check("rst_req_err", c_req_err, 0);
      check("rst_q_count", c_q_count, 0);
      check("rst_q_full", c_q_full, 0);
      check("rst_req_ready", c_req_ready, 1);

      // Close-page read
      push_req(0, ADDR_A);
      run(80, 1'b0);
      check("t1_ev_count", ev_cyc.size(), 5);
      check_ev("t1_act0", 0, CMD_ACT0, 2);
      if (ev_cyc.size() > 0) begin
         check("t1_act0_bg", ev_bg[0], 1);
         check("t1_act0_ba", ev_ba[0], 3);
         check("t1_act0_row", ev_row[0], 1);
      end
      check_ev("t1_act1", 1, CMD_ACT1, 3);
      check_ev("t1_rd0", 2, CMD_RD0, 41);
      if (ev_cyc.size() > 2) check("t1_rd0_col", ev_col[2], 0);
      check_ev("t1_rd1", 3, CMD_RD1, 42);
      check_ev("t1_pre", 4, CMD_PRE, 78);
      check("t1_q_count", c_q_count, 0);

      // Close-page writes, back to back
      reset_dut();
      push_req(1, ADDR_A);
      push_req(1, ADDR_A);
      run(200, 1'b0);
      check_ev("t2_wr0", 2, CMD_WR0, 41);
      check_ev("t2_wr1", 3, CMD_WR1, 42);
      check_ev("t2_pre", 4, CMD_PRE, 159);
      check_ev("t2_act0_b", 5, CMD_ACT0, 198);

      // Open-page hit pair then row conflict
      reset_dut();
      push_req(0, ADDR_A);
      push_req(0, ADDR_A + 34'd4);
      push_req(0, ADDR_A + 34'h4_0000);
      run(160, 1'b1);
      check("t3_ev_count", ev_cyc.size(), 11);
      check_ev("t3_act0", 0, CMD_ACT0, 2);
      check_ev("t3_rd0_a", 2, CMD_RD0, 41);
      check_ev("t3_rd0_b", 4, CMD_RD0, 53);
      if (ev_cyc.size() > 4) check("t3_rd0_b_col", ev_col[4], 1);
      check_ev("t3_pre", 6, CMD_PRE, 78);
      check_ev("t3_act0_c", 7, CMD_ACT0, 117);
      if (ev_cyc.size() > 7) check("t3_act0_c_row", ev_row[7], 2);
      check_ev("t3_rd0_c", 9, CMD_RD0, 156);

      // Fill while stalled on tRCD
      reset_dut();
      for (int i = 0; i < 17; i++) push_req(0, ADDR_A);
      run(16, 1'b0);
      check("t4_count_full", c_q_count, 16);
      check("t4_q_full", c_q_full, 1);
      check("t4_ready_low", c_req_ready, 0);
      run(26, 1'b0);
      check("t4_count_hold", c_q_count, 16);
      run(1, 1'b0);
      check("t4_count_pop", c_q_count, 15);
      check("t4_17th_pending", stim_op.size(), 1);
      check_ev("t4_rd1", 3, CMD_RD1, 42);

      // Illegal op, then ifetch
      reset_dut();
      push_req(3, ADDR_A);
      run(1, 1'b0);
      check("t5_err_pulse", c_req_err, 1);
      check("t5_err_count", c_q_count, 0);
      run(1, 1'b0);
      check("t5_err_clear", c_req_err, 0);
      check("t5_no_cmd", ev_cyc.size(), 0);
      reset_dut();
      push_req(2, ADDR_A);
      run(45, 1'b0);
      check_ev("t5_if_rd0", 2, CMD_RD0, 41);
      check_ev("t5_if_rd1", 3, CMD_RD1, 42);

      // Reset right after ACT1
      reset_dut();
      push_req(0, ADDR_A);
      run(4, 1'b0);
      check_ev("t6_act1", 1, CMD_ACT1, 3);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("t6_rst_valid", c_cmd_valid, 0);
      check("t6_rst_count", c_q_count, 0);
      clear_log();
      run(50, 1'b0);
      check("t6_no_pre", ev_cyc.size(), 0);
      clear_log();
      push_req(0, ADDR_A);
      run(5, 1'b0);
      check_ev("t6_act0", 0, CMD_ACT0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
